// File: rtl/mul_share_arbiter_pkg.sv
// Shared definitions for the shared-multiplier arbiter: FSM state encoding,
// default operand width and the round-robin requester picker.
package mul_share_arbiter_pkg;

    localparam int DEFAULT_DW = 8;

    // Upper bound on requesters; the picker works on a vector this wide.
    localparam int MAX_REQ = 8;
    localparam int IDX_W   = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    typedef struct packed {
        logic             valid;
        logic [IDX_W-1:0] idx;
    } rr_pick_t;

    // First set bit of req searching upward from ptr and wrapping at n_req.
    // The loop runs from the far end of the search order back toward ptr so
    // that the last hit written is the closest one to ptr.
    function automatic rr_pick_t rr_first_set(
        input logic [MAX_REQ-1:0] req,
        input logic [IDX_W-1:0]   ptr,
        input int                 n_req
    );
        rr_pick_t         pick;
        int               k;
        logic [IDX_W-1:0] ki;
        pick = '0;
        for (int i = MAX_REQ - 1; i >= 0; i--) begin
            if (i < n_req) begin
                k = int'(ptr) + i;
                if (k >= n_req) begin
                    k = k - n_req;
                end
                ki = IDX_W'(k);
                if (req[ki]) begin
                    pick.valid = 1'b1;
                    pick.idx   = ki;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/mul_share_arbiter_core.sv
// Iterative unsigned shift-add multiplier. A start seen while idle loads the
// operands, then DW work cycles each add one partial product. The product
// register holds its value until the next start.
module shift_add_core #(
    parameter int DW = 8
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [DW-1:0]   a_bi,
    input  logic [DW-1:0]   b_bi,
    output logic            busy_o,
    output logic [2*DW-1:0] y_bo
);

    localparam int CW = $clog2(DW) + 1;

    logic            working;
    logic [CW-1:0]   cnt;
    logic [2*DW-1:0] mcand;
    logic [DW-1:0]   mplier;
    logic [2*DW-1:0] acc;

    // Load on start, then one partial product per cycle; no early exit on zero.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            working <= 1'b0;
            cnt     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
        end else if (!working) begin
            if (start_i) begin
                working <= 1'b1;
                cnt     <= '0;
                mcand   <= (2*DW)'(a_bi);
                mplier  <= b_bi;
                acc     <= '0;
            end
        end else begin
            if (mplier[0]) begin
                acc <= acc + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + CW'(1);
            if (cnt == CW'(DW - 1)) begin
                working <= 1'b0;
            end
        end
    end

    assign busy_o = working | start_i;
    assign y_bo   = acc;

endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter sharing one shift-add multiplier between N_REQ
// requesters. Operands of the winner are captured in IDLE, the core is
// started for one cycle, and the product is returned with a done pulse on
// the owner's bit. Operations never overlap.
module mul_share_arbiter
    import mul_share_arbiter_pkg::*;
#(
    parameter int N_REQ = 2,
    parameter int DW    = DEFAULT_DW
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [N_REQ-1:0]    req_i,
    input  logic [N_REQ*DW-1:0] a_i,
    input  logic [N_REQ*DW-1:0] b_i,
    output logic [N_REQ-1:0]    grant_o,
    output logic [N_REQ-1:0]    done_o,
    output logic [2*DW-1:0]     y_o,
    output logic                busy_o
);

    arb_state_t       state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] owner;
    logic [DW-1:0]    a_q;
    logic [DW-1:0]    b_q;
    logic             core_start;
    logic             core_busy;
    logic [2*DW-1:0]  core_y;

    logic [MAX_REQ-1:0] req_ext;
    rr_pick_t           pick;
    logic [DW-1:0]      a_sel;
    logic [DW-1:0]      b_sel;
    logic [N_REQ-1:0]   grant_next;

    // Pick the next winner and mux out its operand slices.
    always_comb begin
        req_ext               = '0;
        req_ext[N_REQ-1:0]    = req_i;
        pick                  = rr_first_set(req_ext, ptr, N_REQ);
        a_sel                 = '0;
        b_sel                 = '0;
        grant_next            = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (pick.idx == IDX_W'(k)) begin
                a_sel         = a_i[k*DW +: DW];
                b_sel         = b_i[k*DW +: DW];
                grant_next[k] = 1'b1;
            end
        end
    end

    // Arbitration FSM with registered grant, done, result and core start.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= IDLE;
            ptr        <= '0;
            owner      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            core_start <= 1'b0;
            grant_o    <= '0;
            done_o     <= '0;
            y_o        <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick.valid) begin
                        owner      <= pick.idx;
                        a_q        <= a_sel;
                        b_q        <= b_sel;
                        grant_o    <= grant_next;
                        core_start <= 1'b1;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    core_start <= 1'b0;
                    state      <= WAIT;
                end
                WAIT: begin
                    if (!core_busy) begin
                        y_o    <= core_y;
                        done_o <= grant_o;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done_o  <= '0;
                    grant_o <= '0;
                    ptr     <= (owner == IDX_W'(N_REQ - 1)) ? '0 : owner + IDX_W'(1);
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy_o = (state != IDLE);

    shift_add_core #(
        .DW (DW)
    ) u_core (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (core_start),
        .a_bi    (a_q),
        .b_bi    (b_q),
        .busy_o  (core_busy),
        .y_bo    (core_y)
    );

endmodule
